// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_pkg
//  Purpose  : Shared opcode constants and the decoded-instruction record for
//             the RV32I/RV64I decode stage.
//  Contents : OPC_* major opcodes, IMM_MAX_W, typedef dec_t
//  Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

   // The immediate is carried at the widest supported XLEN. It is always
   // sign-extended, so narrower cores simply take the low XLEN bits.
   localparam int IMM_MAX_W = 64;

   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

   typedef struct packed {
      logic [4:0]           rs1;
      logic [4:0]           rs2;
      logic [4:0]           rd;
      logic [IMM_MAX_W-1:0] imm;
      logic [6:0]           opcode;
      logic [3:0]           op;
      logic                 ill;
   } dec_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/id_decode_comb.sv
`default_nettype none
// ============================================================================
//  Module   : id_decode_comb
//  Purpose  : Purely combinational RISC-V instruction decoder (RV32I/RV64I).
//  Ports    : instr  in  32     raw instruction word
//             dec    out dec_t  register indices, sign-extended immediate,
//                               opcode, {alt,funct3} op code, illegal flag
//  Revision : 1.0 - initial release
// ============================================================================
module id_decode_comb
   import riscv_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int SYS_EN = 1
)(
   input  logic [31:0] instr,
   output dec_t        dec
);

   localparam bit C_RV64 = (XLEN == 64);
   localparam bit C_SYS  = (SYS_EN != 0);

   logic [6:0]  w_opc;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic [63:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

   assign w_opc = instr[6:0];
   assign w_f3  = instr[14:12];
   assign w_f7  = instr[31:25];

   assign w_imm_i = {{52{instr[31]}}, instr[31:20]};
   assign w_imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
   assign w_imm_b = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign w_imm_u = {{32{instr[31]}}, instr[31:12], 12'b0};
   assign w_imm_j = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   always_comb begin
      dec        = '0;
      dec.opcode = w_opc;
      dec.op     = {1'b0, w_f3};
      case (w_opc)
         OPC_LUI, OPC_AUIPC: begin
            dec.rd  = instr[11:7];
            dec.imm = w_imm_u;
         end
         OPC_JAL: begin
            dec.rd  = instr[11:7];
            dec.imm = w_imm_j;
         end
         OPC_JALR: begin
            dec.rd  = instr[11:7];
            dec.rs1 = instr[19:15];
            dec.imm = w_imm_i;
            dec.ill = (w_f3 != 3'd0);
         end
         OPC_BRANCH: begin
            dec.rs1 = instr[19:15];
            dec.rs2 = instr[24:20];
            dec.imm = w_imm_b;
            dec.ill = (w_f3[2:1] == 2'b01);
         end
         OPC_LOAD: begin
            dec.rd  = instr[11:7];
            dec.rs1 = instr[19:15];
            dec.imm = w_imm_i;
            // LD and LWU only exist on RV64
            dec.ill = (w_f3 == 3'd7) || (!C_RV64 && ((w_f3 == 3'd3) || (w_f3 == 3'd6)));
         end
         OPC_STORE: begin
            dec.rs1 = instr[19:15];
            dec.rs2 = instr[24:20];
            dec.imm = w_imm_s;
            dec.ill = C_RV64 ? (w_f3 > 3'd3) : (w_f3 > 3'd2);
         end
         OPC_OP_IMM: begin
            dec.rd  = instr[11:7];
            dec.rs1 = instr[19:15];
            dec.imm = w_imm_i;
            if (w_f3 == 3'b001) begin
               // RV64 uses a 6-bit shamt, so bit 25 belongs to the shift amount
               dec.ill = C_RV64 ? (|instr[31:26]) : (|instr[31:25]);
            end else if (w_f3 == 3'b101) begin
               dec.op[3] = instr[30];
               dec.ill   = instr[31] | (|instr[29:26]) | (!C_RV64 & instr[25]);
            end
         end
         OPC_OP: begin
            dec.rd  = instr[11:7];
            dec.rs1 = instr[19:15];
            dec.rs2 = instr[24:20];
            if ((w_f3 == 3'b000) || (w_f3 == 3'b101)) begin
               dec.op[3] = instr[30];
               dec.ill   = !((w_f7 == 7'h00) || (w_f7 == 7'h20));
            end else begin
               dec.ill = (w_f7 != 7'h00);
            end
         end
         OPC_OP_IMM_32: begin
            dec.rd  = instr[11:7];
            dec.rs1 = instr[19:15];
            dec.imm = w_imm_i;
            if (w_f3 == 3'b101) dec.op[3] = instr[30];
            dec.ill = !C_RV64 || !((w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b101));
         end
         OPC_OP_32: begin
            dec.rd  = instr[11:7];
            dec.rs1 = instr[19:15];
            dec.rs2 = instr[24:20];
            if ((w_f3 == 3'b000) || (w_f3 == 3'b101)) begin
               dec.op[3] = instr[30];
               dec.ill   = !C_RV64 || !((w_f7 == 7'h00) || (w_f7 == 7'h20));
            end else if (w_f3 == 3'b001) begin
               dec.ill = !C_RV64 || (w_f7 != 7'h00);
            end else begin
               dec.ill = 1'b1;
            end
         end
         OPC_MISC_MEM, OPC_SYSTEM: begin
            dec.rd  = instr[11:7];
            dec.rs1 = instr[19:15];
            dec.imm = w_imm_i;
            dec.ill = !C_SYS;
         end
         default: dec.ill = 1'b1;
      endcase
   end

endmodule : id_decode_comb
`default_nettype wire

// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : id_stage_pipe
//  Purpose  : Registered decode stage between IF and EX with valid/ready on
//             both sides, a one-entry skid buffer and a synchronous flush.
//  Ports    : clk, reset_n (async, active low), flush
//             in_valid/in_ready/in_instr/in_pc      - from fetch
//             out_valid/out_ready/out_pc            - toward execute
//             rs1, rs2, rd, imm, opcode, op, ill    - decoded fields
//  Revision : 1.0 - initial release
// ============================================================================
module id_stage_pipe
   import riscv_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int PC_W   = 32,
   parameter int SYS_EN = 1
)(
   input  logic            clk,
   input  logic            reset_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic [XLEN-1:0] imm,
   output logic [6:0]      opcode,
   output logic [3:0]      op,
   output logic            ill
);

   // EMPTY: nothing held, ONE: output register full, TWO: output + skid full
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t          r_state, w_state_nxt;
   dec_t            w_in_dec;
   dec_t            r_out_dec, r_skid_dec;
   logic [PC_W-1:0] r_out_pc, r_skid_pc;
   logic            w_accept, w_deq;
   logic            w_load_out, w_out_from_skid, w_load_skid;

   id_decode_comb #(
      .XLEN   (XLEN),
      .SYS_EN (SYS_EN)
   ) u_dec (
      .instr (in_instr),
      .dec   (w_in_dec)
   );

   // Both handshake outputs come straight from the state flop, so in_ready
   // never depends combinationally on out_ready.
   assign in_ready  = (r_state != TWO);
   assign out_valid = (r_state != EMPTY);
   assign w_accept  = in_valid & in_ready;
   assign w_deq     = out_valid & out_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= EMPTY;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_load_out      = 1'b0;
      w_out_from_skid = 1'b0;
      w_load_skid     = 1'b0;
      if (flush) begin
         w_state_nxt = EMPTY;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_accept) begin
                  w_state_nxt = ONE;
                  w_load_out  = 1'b1;
               end
            end
            ONE: begin
               case ({w_accept, w_deq})
                  2'b10: begin
                     w_state_nxt = TWO;
                     w_load_skid = 1'b1;
                  end
                  2'b01: w_state_nxt = EMPTY;
                  2'b11: w_load_out  = 1'b1;
                  default: ;
               endcase
            end
            TWO: begin
               // in_ready is low here, so no new entry can arrive alongside
               if (w_deq) begin
                  w_state_nxt     = ONE;
                  w_load_out      = 1'b1;
                  w_out_from_skid = 1'b1;
               end
            end
            default: w_state_nxt = EMPTY;
         endcase
      end
   end

   // Data registers only load from a real source, so an X instruction word
   // presented with in_valid low never reaches the outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out_pc   <= '0;
         r_out_dec  <= '0;
         r_skid_pc  <= '0;
         r_skid_dec <= '0;
      end else begin
         if (w_load_out) begin
            r_out_pc  <= w_out_from_skid ? r_skid_pc  : in_pc;
            r_out_dec <= w_out_from_skid ? r_skid_dec : w_in_dec;
         end
         if (w_load_skid) begin
            r_skid_pc  <= in_pc;
            r_skid_dec <= w_in_dec;
         end
      end
   end

   assign out_pc = r_out_pc;
   assign rs1    = r_out_dec.rs1;
   assign rs2    = r_out_dec.rs2;
   assign rd     = r_out_dec.rd;
   assign imm    = r_out_dec.imm[XLEN-1:0];
   assign opcode = r_out_dec.opcode;
   assign op     = r_out_dec.op;
   assign ill    = r_out_dec.ill;

   // Upper immediate bits are pure sign extension on narrow cores
   if (XLEN < IMM_MAX_W) begin : g_imm_unused
      logic w_unused_imm_hi;
      assign w_unused_imm_hi = ^r_out_dec.imm[IMM_MAX_W-1:XLEN];
   end

endmodule : id_stage_pipe
`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_stage_pipe
//  Purpose  : Self-checking bench for id_stage_pipe. An RV32 and an RV64
//             instance see identical stimulus; expected entries are queued on
//             accept and compared field by field on each output transfer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_id_stage_pipe;

   typedef struct {
      logic [31:0] pc;
      logic [6:0]  opcode;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm;
      logic [3:0]  op;
      logic        ill;
      logic        ill64;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n, flush, in_valid, out_ready;
   logic [31:0] in_instr, in_pc;

   logic        in_ready, out_valid, ill;
   logic [31:0] out_pc, imm;
   logic [4:0]  rs1, rs2, rd;
   logic [6:0]  opcode;
   logic [3:0]  op;

   logic        in_ready_64, out_valid_64, ill_64;
   logic [31:0] out_pc_64;
   logic [63:0] imm_64;
   logic [4:0]  rs1_64, rs2_64, rd_64;
   logic [6:0]  opcode_64;
   logic [3:0]  op_64;

   exp_t q[$];
   int   checks = 0;
   int   passed = 0;
   logic acc;

   always #5 clk = ~clk;

   id_stage_pipe #(.XLEN(32), .PC_W(32), .SYS_EN(1)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .opcode(opcode), .op(op), .ill(ill)
   );

   id_stage_pipe #(.XLEN(64), .PC_W(32), .SYS_EN(1)) dut64 (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_64), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid_64), .out_ready(out_ready), .out_pc(out_pc_64),
      .rs1(rs1_64), .rs2(rs2_64), .rd(rd_64), .imm(imm_64), .opcode(opcode_64),
      .op(op_64), .ill(ill_64)
   );

   function automatic exp_t mk(input logic [31:0] pc, input logic [6:0] opc,
                               input logic [4:0] rd_e, input logic [4:0] rs1_e,
                               input logic [4:0] rs2_e, input logic [31:0] imm_e,
                               input logic [3:0] op_e, input logic ill_e,
                               input logic ill64_e);
      exp_t e;
      e.pc = pc; e.opcode = opc; e.rd = rd_e; e.rs1 = rs1_e; e.rs2 = rs2_e;
      e.imm = imm_e; e.op = op_e; e.ill = ill_e; e.ill64 = ill64_e;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      assert (got === want) passed++;
      else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
   endtask

   // Drive one cycle at the falling edge; score the transfers that happen
   // at the following rising edge.
   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl, input exp_t e,
                        output logic accepted);
      exp_t h;
      @(negedge clk);
      in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
      #1;
      accepted = 1'b0;
      if (fl) begin
         q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_out", {32'd0, out_pc}, 64'hDEAD);
            end else begin
               h = q.pop_front();
               chk("pc",     {32'd0, out_pc}, {32'd0, h.pc});
               chk("opcode", {57'd0, opcode}, {57'd0, h.opcode});
               chk("rd",     {59'd0, rd},     {59'd0, h.rd});
               chk("rs1",    {59'd0, rs1},    {59'd0, h.rs1});
               chk("rs2",    {59'd0, rs2},    {59'd0, h.rs2});
               chk("imm",    {32'd0, imm},    {32'd0, h.imm});
               chk("op",     {60'd0, op},     {60'd0, h.op});
               chk("ill",    {63'd0, ill},    {63'd0, h.ill});
               chk("ill64",  {63'd0, ill_64}, {63'd0, h.ill64});
               chk("imm64",  imm_64,          {{32{h.imm[31]}}, h.imm});
            end
         end
         accepted = in_valid && in_ready;
         if (accepted) q.push_back(e);
      end
      @(posedge clk);
   endtask

   task automatic drain();
      exp_t idle_e;
      logic a;
      idle_e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 20 && q.size() > 0; i++)
         drive(1'b0, 32'hxxxxxxxx, 32'h0, 1'b1, 1'b0, idle_e, a);
      chk("drain_empty", 64'(q.size()), 64'd0);
   endtask

   localparam logic [31:0] I_ADDI  = 32'h00500093;
   localparam logic [31:0] I_SUB   = 32'h402081B3;
   localparam logic [31:0] I_ADD   = 32'h002081B3;
   localparam logic [31:0] I_LUI   = 32'h123452B7;
   localparam logic [31:0] I_BEQ   = 32'h00208463;
   localparam logic [31:0] I_SW    = 32'hFE20AE23;
   localparam logic [31:0] I_LD    = 32'h0000B503;
   localparam logic [31:0] I_ADDIW = 32'h0010851B;
   localparam logic [31:0] I_SRAI  = 32'h4030D093;
   localparam logic [31:0] I_ECALL = 32'h00000073;
   localparam logic [31:0] I_BAD   = 32'h0000007F;

   initial begin
      exp_t idle_e;
      int   n;
      idle_e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = 32'h0; in_pc = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
      chk("rst_out_pc",    {32'd0, out_pc},    64'd0);
      chk("rst_rd",        {59'd0, rd},        64'd0);
      chk("rst_imm",       {32'd0, imm},       64'd0);
      chk("rst_ill",       {63'd0, ill},       64'd0);
      reset_n = 1'b1;

      // 1: addi, one-cycle latency
      drive(1'b1, I_ADDI, 32'h100, 1'b1, 1'b0, mk(32'h100, 7'h13, 1, 0, 0, 5, 4'h0, 0, 0), acc);
      #1 chk("latency_out_valid", {63'd0, out_valid}, 64'd1);

      // 2: sub / add
      drive(1'b1, I_SUB, 32'h104, 1'b1, 1'b0, mk(32'h104, 7'h33, 3, 1, 2, 0, 4'h8, 0, 0), acc);
      drive(1'b1, I_ADD, 32'h108, 1'b1, 1'b0, mk(32'h108, 7'h33, 3, 1, 2, 0, 4'h0, 0, 0), acc);
      drain();

      // 3: stall, fill skid, back-pressure, ordered release
      drive(1'b1, I_LUI, 32'h200, 1'b0, 1'b0, mk(32'h200, 7'h37, 5, 0, 0, 32'h12345000, 4'h5, 0, 0), acc);
      drive(1'b1, I_BEQ, 32'h204, 1'b0, 1'b0, mk(32'h204, 7'h63, 0, 1, 2, 8, 4'h0, 0, 0), acc);
      drive(1'b1, I_SW,  32'h208, 1'b0, 1'b0, mk(32'h208, 7'h23, 0, 1, 2, 32'hFFFFFFFC, 4'h2, 0, 0), acc);
      chk("third_not_accepted", {63'd0, acc}, 64'd0);
      #1 chk("full_in_ready", {63'd0, in_ready}, 64'd0);
      n = 0;
      do begin
         drive(1'b1, I_SW, 32'h208, 1'b1, 1'b0, mk(32'h208, 7'h23, 0, 1, 2, 32'hFFFFFFFC, 4'h2, 0, 0), acc);
         n++;
      end while (!acc && n < 10);
      chk("third_accepted", {63'd0, acc}, 64'd1);
      drain();

      // 4: flush with two entries held
      drive(1'b1, I_ADDI, 32'h300, 1'b0, 1'b0, mk(32'h300, 7'h13, 1, 0, 0, 5, 4'h0, 0, 0), acc);
      drive(1'b1, I_ADD,  32'h304, 1'b0, 1'b0, mk(32'h304, 7'h33, 3, 1, 2, 0, 4'h0, 0, 0), acc);
      drive(1'b1, I_SUB,  32'h308, 1'b0, 1'b1, idle_e, acc);
      #1;
      chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
      chk("flush_in_ready",  {63'd0, in_ready},  64'd1);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 32'hxxxxxxxx, 32'h0, 1'b1, 1'b0, idle_e, acc);
         #1 chk("post_flush_quiet", {63'd0, out_valid}, 64'd0);
      end

      // 5: XLEN-dependent legality, shifts, system, unknown opcode
      drive(1'b1, I_LD,    32'h400, 1'b1, 1'b0, mk(32'h400, 7'h03, 10, 1, 0, 0, 4'h3, 1, 0), acc);
      drive(1'b1, I_ADDIW, 32'h404, 1'b1, 1'b0, mk(32'h404, 7'h1B, 10, 1, 0, 1, 4'h0, 1, 0), acc);
      drive(1'b1, I_SRAI,  32'h408, 1'b1, 1'b0, mk(32'h408, 7'h13, 1, 1, 0, 32'h403, 4'hD, 0, 0), acc);
      drive(1'b1, I_ECALL, 32'h40C, 1'b1, 1'b0, mk(32'h40C, 7'h73, 0, 0, 0, 0, 4'h0, 0, 0), acc);
      drive(1'b1, I_BAD,   32'h410, 1'b1, 1'b0, mk(32'h410, 7'h7F, 0, 0, 0, 0, 4'h0, 1, 1), acc);
      drain();

      // 6: async reset while two entries are stalled
      drive(1'b1, I_ADDI, 32'h500, 1'b0, 1'b0, mk(32'h500, 7'h13, 1, 0, 0, 5, 4'h0, 0, 0), acc);
      drive(1'b1, I_LUI,  32'h504, 1'b0, 1'b0, mk(32'h504, 7'h37, 5, 0, 0, 32'h12345000, 4'h5, 0, 0), acc);
      @(negedge clk);
      in_valid = 1'b0;
      reset_n  = 1'b0;
      #1;
      q.delete();
      chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("arst_in_ready",  {63'd0, in_ready},  64'd1);
      chk("arst_out_pc",    {32'd0, out_pc},    64'd0);
      chk("arst_rs1",       {59'd0, rs1},       64'd0);
      chk("arst_rd",        {59'd0, rd},        64'd0);
      chk("arst_imm",       {32'd0, imm},       64'd0);
      chk("arst_opcode",    {57'd0, opcode},    64'd0);
      chk("arst_op",        {60'd0, op},        64'd0);
      chk("arst_ill",       {63'd0, ill},       64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1 chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
      drive(1'b1, I_ADDI, 32'h600, 1'b1, 1'b0, mk(32'h600, 7'h13, 1, 0, 0, 5, 4'h0, 0, 0), acc);
      drain();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule : tb_id_stage_pipe
`default_nettype wire
